// File: rtl/console_pkg.sv
// Shared definitions for the text console: control codes, FSM states and the
// physical-row wrap used by both the cursor and the renderer read path.
package console_pkg;

  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] TAB      = 8'h09;
  localparam logic [7:0] FF       = 8'h0C;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] SUB_CHAR = 8'h2D;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_LINE = 2'd1,
    CLEAR_ALL  = 2'd2
  } state_t;

  // Both operands are below rows, so a single conditional subtract suffices.
  function automatic logic [15:0] wrap_row(input logic [15:0] sum, input logic [15:0] rows);
    logic [15:0] res;
    if (sum >= rows) begin
      res = sum - rows;
    end else begin
      res = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/console_char_ram.sv
// Character storage: one write port and one registered read port with
// read-before-write behaviour on address collision.
module console_char_ram #(
  parameter int DEPTH  = 2400,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem_r [DEPTH];
  logic [7:0] rdata_r;

  // Write port; contents are left unreset since the console clears them itself.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read returns the pre-write contents on a same-cycle collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= 8'h00;
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/text_console.sv
// Character-cell console: byte interpreter, cursor, scroll/page-clear sequencer,
// cursor blink and a one-cycle read port for the pixel renderer.
module text_console
  import console_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int COL_W        = 7,
  parameter int ROW_W        = 5,
  parameter int TAB_W        = 8,
  parameter int SCROLL_MODE  = 1,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       in_char,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_char,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic             cursor_on,
  output logic             busy
);

  localparam int CELLS   = COLS * ROWS;
  localparam int ADDR_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(32'(row) * 32'(COLS) + 32'(col));
  endfunction

  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                input logic [ROW_W-1:0] top);
    return ROW_W'(wrap_row(16'(lrow) + 16'(top), 16'(ROWS)));
  endfunction

  state_t             state_r;
  logic [COL_W-1:0]   cur_col_r;
  logic [ROW_W-1:0]   cur_row_r;
  logic [ROW_W-1:0]   top_row_r;
  logic [COL_W-1:0]   clr_col_r;
  logic [ROW_W-1:0]   clr_row_r;
  logic [ROW_W-1:0]   line_row_r;
  logic               pend_r;
  logic               in_ready_r;
  logic               busy_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               cursor_on_r;
  logic               rd_oor_r;

  logic               byte_acc_s;
  logic               wr_en_s;
  logic [COL_W-1:0]   wr_col_s;
  logic [7:0]         wr_data_s;
  logic [COL_W-1:0]   nxt_col_s;
  logic               adv_row_s;
  logic               is_ff_s;
  logic               overflow_s;
  logic               seq_done_s;
  logic               go_all_s;
  logic               go_line_s;
  logic               go_idle_s;
  logic               busy_next_s;
  int unsigned        tab_stop_s;
  logic [ROW_W-1:0]   cur_phys_s;
  logic               ram_we_s;
  logic [ADDR_W-1:0]  ram_waddr_s;
  logic [7:0]         ram_wdata_s;
  logic [ADDR_W-1:0]  ram_raddr_s;
  logic               rd_oor_s;
  logic [7:0]         ram_q_s;

  assign byte_acc_s = in_valid && in_ready_r && !clear && (state_r == IDLE);
  assign cur_phys_s = phys_row(cur_row_r, top_row_r);
  assign tab_stop_s = (32'(cur_col_r) / 32'(TAB_W) + 32'd1) * 32'(TAB_W);

  // Decode the accepted byte into a RAM write and the next cursor column.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_col_s  = cur_col_r;
    wr_data_s = SPACE;
    nxt_col_s = cur_col_r;
    adv_row_s = 1'b0;
    is_ff_s   = 1'b0;
    if (byte_acc_s) begin
      case (in_char)
        LF: begin
          nxt_col_s = {COL_W{1'b0}};
          adv_row_s = 1'b1;
        end
        CR: nxt_col_s = {COL_W{1'b0}};
        BS: begin
          if (cur_col_r != {COL_W{1'b0}}) begin
            nxt_col_s = cur_col_r - COL_W'(1);
            wr_col_s  = cur_col_r - COL_W'(1);
            wr_en_s   = 1'b1;
          end else begin
            nxt_col_s = cur_col_r;
          end
        end
        TAB: begin
          if (tab_stop_s >= 32'(COLS)) begin
            nxt_col_s = {COL_W{1'b0}};
            adv_row_s = 1'b1;
          end else begin
            nxt_col_s = COL_W'(tab_stop_s);
          end
        end
        FF: is_ff_s = 1'b1;
        default: begin
          wr_en_s   = 1'b1;
          wr_data_s = (in_char >= PRINT_LO && in_char <= PRINT_HI) ? in_char : SUB_CHAR;
          if (cur_col_r == LAST_COL) begin
            nxt_col_s = {COL_W{1'b0}};
            adv_row_s = 1'b1;
          end else begin
            nxt_col_s = cur_col_r + COL_W'(1);
          end
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  assign overflow_s = adv_row_s && (cur_row_r == LAST_ROW);
  assign seq_done_s = ((state_r == CLEAR_LINE) && (clr_col_r == LAST_COL)) ||
                      ((state_r == CLEAR_ALL) && (clr_col_r == LAST_COL) && (clr_row_r == LAST_ROW));
  assign go_line_s  = byte_acc_s && overflow_s && (SCROLL_MODE != 0);
  // A clear request (input or FF) always beats whatever the byte would have done.
  assign go_all_s   = ((state_r == IDLE) &&
                       (clear || (byte_acc_s && (is_ff_s || (overflow_s && (SCROLL_MODE == 0)))))) ||
                      (seq_done_s && (pend_r || clear));
  assign go_idle_s  = seq_done_s && !pend_r && !clear;
  assign busy_next_s = go_all_s || go_line_s || ((state_r != IDLE) && !go_idle_s);

  // Select the RAM write source: interpreter in IDLE, clear sequencer otherwise.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = {ADDR_W{1'b0}};
    ram_wdata_s = SPACE;
    case (state_r)
      IDLE: begin
        ram_we_s    = wr_en_s;
        ram_waddr_s = cell_addr(cur_phys_s, wr_col_s);
        ram_wdata_s = wr_data_s;
      end
      CLEAR_LINE: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = cell_addr(line_row_r, clr_col_r);
      end
      CLEAR_ALL: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = cell_addr(clr_row_r, clr_col_r);
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  // Main sequencer: cursor, scroll origin, clear counters and handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= CLEAR_ALL;
      cur_col_r  <= {COL_W{1'b0}};
      cur_row_r  <= {ROW_W{1'b0}};
      top_row_r  <= {ROW_W{1'b0}};
      clr_col_r  <= {COL_W{1'b0}};
      clr_row_r  <= {ROW_W{1'b0}};
      line_row_r <= {ROW_W{1'b0}};
      pend_r     <= 1'b0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b1;
    end else if (go_all_s) begin
      state_r    <= CLEAR_ALL;
      cur_col_r  <= {COL_W{1'b0}};
      cur_row_r  <= {ROW_W{1'b0}};
      top_row_r  <= {ROW_W{1'b0}};
      clr_col_r  <= {COL_W{1'b0}};
      clr_row_r  <= {ROW_W{1'b0}};
      pend_r     <= 1'b0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (go_line_s) begin
            // The old top row becomes the new bottom line and is blanked.
            state_r    <= CLEAR_LINE;
            line_row_r <= top_row_r;
            top_row_r  <= ROW_W'(wrap_row(16'(top_row_r) + 16'd1, 16'(ROWS)));
            cur_col_r  <= {COL_W{1'b0}};
            clr_col_r  <= {COL_W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else if (byte_acc_s) begin
            cur_col_r <= nxt_col_s;
            if (adv_row_s) begin
              cur_row_r <= cur_row_r + ROW_W'(1);
            end
          end
        end
        CLEAR_LINE: begin
          if (clear) begin
            pend_r <= 1'b1;
          end
          if (seq_done_s) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            clr_col_r <= clr_col_r + COL_W'(1);
          end
        end
        CLEAR_ALL: begin
          if (clear) begin
            pend_r <= 1'b1;
          end
          if (seq_done_s) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end else if (clr_col_r == LAST_COL) begin
            clr_col_r <= {COL_W{1'b0}};
            clr_row_r <= clr_row_r + ROW_W'(1);
          end else begin
            clr_col_r <= clr_col_r + COL_W'(1);
          end
        end
        default: begin
          state_r    <= CLEAR_ALL;
          clr_col_r  <= {COL_W{1'b0}};
          clr_row_r  <= {ROW_W{1'b0}};
          in_ready_r <= 1'b0;
          busy_r     <= 1'b1;
        end
      endcase
    end
  end

  // Blink timer; forced dark while a clear runs, restarted lit by each byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      cursor_on_r <= 1'b0;
    end else if (busy_next_s) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      cursor_on_r <= 1'b0;
    end else if (byte_acc_s) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      cursor_on_r <= 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      cursor_on_r <= ~cursor_on_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
    end
  end

  assign rd_oor_s    = (32'(rd_col) >= 32'(COLS)) || (32'(rd_row) >= 32'(ROWS));
  assign ram_raddr_s = rd_oor_s ? {ADDR_W{1'b0}} : cell_addr(phys_row(rd_row, top_row_r), rd_col);

  // Out-of-range flag travels alongside the RAM read register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_oor_r <= 1'b0;
    end else begin
      rd_oor_r <= rd_oor_s;
    end
  end

  console_char_ram #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we_s),
    .waddr   (ram_waddr_s),
    .wdata   (ram_wdata_s),
    .raddr   (ram_raddr_s),
    .rdata   (ram_q_s)
  );

  assign rd_char    = rd_oor_r ? SPACE : ram_q_s;
  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign cursor_col = cur_col_r;
  assign cursor_row = cur_row_r;
  assign cursor_on  = cursor_on_r;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: a page-clear and a scrolling instance driven against
// a logical-screen model (rows shift on scroll, no physical-row bookkeeping).
module tb_text_console;

  localparam int COLS  = 8;
  localparam int ROWS  = 4;
  localparam int COL_W = 4;
  localparam int ROW_W = 3;
  localparam int TAB_W = 4;
  localparam int BLINK = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic [7:0]       in_char    [2];
  logic             in_valid   [2];
  logic             in_ready   [2];
  logic             clear      [2];
  logic [COL_W-1:0] rd_col     [2];
  logic [ROW_W-1:0] rd_row     [2];
  logic [7:0]       rd_char    [2];
  logic [COL_W-1:0] cursor_col [2];
  logic [ROW_W-1:0] cursor_row [2];
  logic             cursor_on  [2];
  logic             busy       [2];

  logic [7:0] scr [2][ROWS][COLS];
  int mcol [2];
  int mrow [2];
  int n_vec;
  int n_err;

  always #5 clk = ~clk;

  text_console #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .TAB_W(TAB_W),
                 .SCROLL_MODE(0), .BLINK_CYCLES(BLINK)) dut_page (
    .clk(clk), .reset_n(reset_n), .in_char(in_char[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .clear(clear[0]), .rd_col(rd_col[0]), .rd_row(rd_row[0]),
    .rd_char(rd_char[0]), .cursor_col(cursor_col[0]), .cursor_row(cursor_row[0]),
    .cursor_on(cursor_on[0]), .busy(busy[0]));

  text_console #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .TAB_W(TAB_W),
                 .SCROLL_MODE(1), .BLINK_CYCLES(BLINK)) dut_scroll (
    .clk(clk), .reset_n(reset_n), .in_char(in_char[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .clear(clear[1]), .rd_col(rd_col[1]), .rd_row(rd_row[1]),
    .rd_char(rd_char[1]), .cursor_col(cursor_col[1]), .cursor_row(cursor_row[1]),
    .cursor_on(cursor_on[1]), .busy(busy[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear(input int d);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[d][r][c] = 8'h20;
    mcol[d] = 0;
    mrow[d] = 0;
  endtask

  // d==1 is the scrolling console, d==0 clears the page.
  task automatic m_newline(input int d, output int bl);
    bl = 0;
    mcol[d] = 0;
    if (mrow[d] < ROWS - 1) begin
      mrow[d]++;
    end else if (d == 1) begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[d][r][c] = scr[d][r+1][c];
      for (int c = 0; c < COLS; c++) scr[d][ROWS-1][c] = 8'h20;
      bl = COLS;
    end else begin
      m_clear(d);
      bl = ROWS * COLS;
    end
  endtask

  task automatic m_put(input int d, input logic [7:0] c, output int bl);
    int t;
    bl = 0;
    case (c)
      8'h0A: m_newline(d, bl);
      8'h0D: mcol[d] = 0;
      8'h08: if (mcol[d] > 0) begin mcol[d]--; scr[d][mrow[d]][mcol[d]] = 8'h20; end
      8'h09: begin
        t = (mcol[d] / TAB_W + 1) * TAB_W;
        if (t >= COLS) m_newline(d, bl);
        else mcol[d] = t;
      end
      8'h0C: begin m_clear(d); bl = ROWS * COLS; end
      default: begin
        scr[d][mrow[d]][mcol[d]] = (c >= 8'h20 && c <= 8'h7E) ? c : 8'h2D;
        mcol[d]++;
        if (mcol[d] == COLS) m_newline(d, bl);
      end
    endcase
  endtask

  task automatic check_cursor(input int d, input string tag);
    check($sformatf("%s_col%0d", tag, d), 32'(cursor_col[d]), 32'(mcol[d]));
    check($sformatf("%s_row%0d", tag, d), 32'(cursor_row[d]), 32'(mrow[d]));
  endtask

  task automatic check_screen(input int d);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        rd_row[d] = ROW_W'(r);
        rd_col[d] = COL_W'(c);
        @(negedge clk);
        check($sformatf("cell%0d_r%0d_c%0d", d, r, c), 32'(rd_char[d]), 32'(scr[d][r][c]));
      end
    rd_row[d] = ROW_W'(1);
    rd_col[d] = COL_W'(COLS + $urandom_range(0, 7));
    @(negedge clk);
    check($sformatf("oor_col%0d", d), 32'(rd_char[d]), 32'h20);
    rd_row[d] = ROW_W'(ROWS + $urandom_range(0, 3));
    rd_col[d] = COL_W'(0);
    @(negedge clk);
    check($sformatf("oor_row%0d", d), 32'(rd_char[d]), 32'h20);
  endtask

  task automatic wait_ready(input int d);
    int g;
    g = 0;
    while (in_ready[d] !== 1'b1 && g < 200) begin g++; @(negedge clk); end
    if (g >= 200) check($sformatf("ready_timeout%0d", d), 32'(in_ready[d]), 32'd1);
  endtask

  task automatic count_busy(input int d, input int clr_at, input int expb, input string tag);
    int n;
    n = 0;
    while (busy[d] === 1'b1 && n < 2000) begin
      if (n == 0) check($sformatf("dark_busy%0d", d), 32'(cursor_on[d]), 32'd0);
      if (n == clr_at) begin clear[d] = 1'b1; in_valid[d] = 1'b1; in_char[d] = 8'h51; end
      else begin clear[d] = 1'b0; in_valid[d] = 1'b0; end
      n++;
      @(negedge clk);
    end
    clear[d] = 1'b0;
    in_valid[d] = 1'b0;
    check(tag, 32'(n), 32'(expb));
    check($sformatf("ready_after%0d", d), 32'(in_ready[d]), 32'd1);
  endtask

  task automatic send(input int d, input logic [7:0] c, input int clr_at);
    int expb;
    wait_ready(d);
    in_char[d] = c;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    m_put(d, c, expb);
    if (clr_at >= 0 && expb > 0) begin
      m_clear(d);
      expb += ROWS * COLS;
    end
    count_busy(d, clr_at, expb, $sformatf("busy_len%0d_%02h", d, c));
    check_cursor(d, $sformatf("cur_%02h", c));
  endtask

  // Clear input together with a valid byte: the byte must be dropped.
  task automatic clear_with_byte(input int d);
    wait_ready(d);
    clear[d] = 1'b1;
    in_valid[d] = 1'b1;
    in_char[d] = 8'h4B;
    @(negedge clk);
    clear[d] = 1'b0;
    in_valid[d] = 1'b0;
    m_clear(d);
    count_busy(d, -1, ROWS * COLS, $sformatf("clr_busy%0d", d));
    check_cursor(d, "clr");
  endtask

  initial begin
    int nb [2];
    int r;
    logic [7:0] b;
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_char[d] = 8'h00; in_valid[d] = 1'b0; clear[d] = 1'b0;
      rd_col[d] = COL_W'(0); rd_row[d] = ROW_W'(0);
      m_clear(d);
      nb[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(in_ready[d]), 32'd0);
      check($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd1);
      check($sformatf("rst_rdchar%0d", d), 32'(rd_char[d]), 32'd0);
      check($sformatf("rst_blink%0d", d), 32'(cursor_on[d]), 32'd0);
      check_cursor(d, "rst");
    end
    reset_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      for (int d = 0; d < 2; d++) if (busy[d] === 1'b1) nb[d]++;
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("init_busy%0d", d), 32'(nb[d]), 32'(ROWS * COLS));
      check($sformatf("init_ready%0d", d), 32'(in_ready[d]), 32'd1);
      check_screen(d);
    end

    // Backspace overwrite and substitution character.
    send(1, 8'h41, -1); send(1, 8'h42, -1); send(1, 8'h08, -1); send(1, 8'h43, -1);
    check("bs_col", 32'(cursor_col[1]), 32'd2);
    send(1, 8'h01, -1);
    check_screen(1);

    // Tab stops, including the wrap to the next line.
    send(1, 8'h0D, -1);
    send(1, 8'h61, -1); send(1, 8'h62, -1); send(1, 8'h63, -1);
    send(1, 8'h09, -1);
    check("tab_col4", 32'(cursor_col[1]), 32'd4);
    send(1, 8'h64, -1);
    send(1, 8'h09, -1);
    check("tab_wrap_row", 32'(cursor_row[1]), 32'd1);

    // Fill the page then overflow, in both modes.
    for (int d = 1; d >= 0; d--) begin
      send(d, 8'h0C, -1);
      for (int k = 0; k < ROWS * COLS; k++) send(d, 8'(8'h21 + k), -1);
      send(d, 8'h58, -1);
      check_screen(d);
    end
    check("scroll_row", 32'(cursor_row[1]), 32'd3);
    check("page_col", 32'(cursor_col[0]), 32'd1);

    // Clear raised with a byte while the bottom line is being blanked.
    for (int k = 0; k < 6; k++) send(1, 8'(8'h61 + k), -1);
    send(1, 8'h5A, 2);
    check_screen(1);

    // Randomised traffic on both consoles.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 150; k++) begin
        r = $urandom_range(0, 99);
        if (r < 60)      b = 8'($urandom_range(32, 126));
        else if (r < 68) b = 8'h0A;
        else if (r < 74) b = 8'h0D;
        else if (r < 82) b = 8'h08;
        else if (r < 90) b = 8'h09;
        else if (r < 92) b = 8'h0C;
        else if (r < 95) b = 8'($urandom_range(14, 31));
        else             b = 8'($urandom_range(127, 255));
        if ($urandom_range(0, 99) < 3) clear_with_byte(d);
        else send(d, b, -1);
        if (k % 25 == 24) check_screen(d);
      end
    end

    // Blink: lit after a byte, toggles after BLINK idle cycles.
    send(1, 8'h7A, -1);
    check("blink_lit", 32'(cursor_on[1]), 32'd1);
    repeat (BLINK - 1) @(negedge clk);
    check("blink_hold", 32'(cursor_on[1]), 32'd1);
    @(negedge clk);
    check("blink_toggle", 32'(cursor_on[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
